// File: rtl/csa_multi_add_pipe_if.sv
// Operand/result handshake bundle for csa_multi_add_pipe; parameters must match the attached adder.
interface csa_multi_add_pipe_if #(
    parameter int NUM_OPS = 3,
    parameter int WIDTH   = 4,
    parameter int SUM_W   = 6
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OPS*WIDTH-1:0] in_ops;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [SUM_W-1:0]         sum;

    modport master (
        output in_valid, in_ops, in_last, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, in_ops, in_last, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/csa_multi_add_pipe.sv
// Multi-operand CSA-tree adder with CPA, two registered stages; CSA_ACC_EN adds group accumulation.
// Latency: 2 cycles from input transfer to out_valid; throughput 1 result/cycle.
// Backpressure: valid/ready per stage; in_ready drops once both stages hold data and out_ready=0.
module csa_multi_add_pipe #(
    parameter int NUM_OPS = 3,
    parameter int WIDTH   = 4,
    parameter int SUM_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_multi_add_pipe_if.slave bus
);

    typedef logic [SUM_W-1:0] word_t;
    typedef struct packed {
        word_t s;
        word_t c;
    } sc_t;

    // Wallace-style reduction: each level compresses every full triple with a 3:2
    // compressor and forwards leftovers, until two vectors remain.
    function automatic sc_t csa_tree(input logic [NUM_OPS*WIDTH-1:0] ops);
        word_t vec [NUM_OPS];
        word_t nxt [NUM_OPS];
        word_t a, b, c;
        int    n, m;
        sc_t   r;
        for (int i = 0; i < NUM_OPS; i++) begin
            vec[i] = word_t'(ops[i*WIDTH +: WIDTH]);
        end
        n = NUM_OPS;
        for (int lvl = 0; lvl < NUM_OPS; lvl++) begin
            if (n > 2) begin
                m = 0;
                for (int i = 0; i < NUM_OPS; i++) begin
                    nxt[i] = '0;
                end
                for (int g = 0; g < NUM_OPS / 3; g++) begin
                    if (3 * g + 2 < n) begin
                        a          = vec[3*g];
                        b          = vec[3*g+1];
                        c          = vec[3*g+2];
                        nxt[m]     = a ^ b ^ c;
                        nxt[m+1]   = ((a & b) | (a & c) | (b & c)) << 1;
                        m          = m + 2;
                    end
                end
                for (int i = 0; i < NUM_OPS; i++) begin
                    if (i >= 3 * (n / 3) && i < n) begin
                        nxt[m] = vec[i];
                        m      = m + 1;
                    end
                end
                vec = nxt;
                n   = m;
            end
        end
        r.s = vec[0];
        r.c = vec[1];
        return r;
    endfunction

    sc_t   tree;
    word_t s_a, c_a, sum_q, ab_sum;
    logic  v_a, v_b, adv_a, adv_b;

    assign tree   = csa_tree(bus.in_ops);
    assign ab_sum = s_a + c_a;

    assign adv_b         = !v_b || bus.out_ready;
    assign adv_a         = !v_a || adv_b;
    assign bus.in_ready  = rst_n && adv_a;
    assign bus.out_valid = v_b;
    assign bus.sum       = sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_a <= 1'b0;
            s_a <= '0;
            c_a <= '0;
        end else if (adv_a) begin
            v_a <= bus.in_valid;
            if (bus.in_valid) begin
                s_a <= tree.s;
                c_a <= tree.c;
            end
        end
    end

`ifdef CSA_ACC_EN
    logic  last_a;
    word_t acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_a <= 1'b0;
        end else if (adv_a && bus.in_valid) begin
            last_a <= bus.in_last;
        end
    end

    // v_b marks a completed group; non-last beats fold into acc without a result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_b   <= 1'b0;
            sum_q <= '0;
            acc   <= '0;
        end else if (adv_b) begin
            if (v_a) begin
                if (last_a) begin
                    sum_q <= acc + ab_sum;
                    acc   <= '0;
                    v_b   <= 1'b1;
                end else begin
                    acc <= acc + ab_sum;
                    v_b <= 1'b0;
                end
            end else begin
                v_b <= 1'b0;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = bus.in_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_b   <= 1'b0;
            sum_q <= '0;
        end else if (adv_b) begin
            v_b <= v_a;
            if (v_a) begin
                sum_q <= ab_sum;
            end
        end
    end
`endif

endmodule
